msrv32_imem_responder: RTL and testbench
========================================

MSRV32_IMEM_RESPONDER -- requirements
Module: msrv32_imem_responder

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 1024, instruction memory depth in 32-bit words (power of two).
REQ-002 SHALL have parameter WAIT_STATES, default 1, stall cycles per fetch, legal range 0..15.
REQ-003 SHALL have parameter NOP_INSTR, default 32'h0000_0013, value driven on instr_out when no valid data.
REQ-004 SHALL have port ms_riscv32_mp_clk_in  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port ms_riscv32_mp_rst_in  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_addr_in  input  32  fetch byte address from the PC mux.
REQ-007 SHALL have port req_in  input  1  fetch request valid.
REQ-008 SHALL have port load_en_in  input  1  memory preload write strobe.
REQ-009 SHALL have port load_addr_in  input  log2(MEM_DEPTH)  preload word index.
REQ-010 SHALL have port load_data_in  input  32  preload word.
REQ-011 SHALL have port instr_out  output  32  fetched instruction, valid when ahb_ready_out=1 in the data cycle.
REQ-012 SHALL have port instr_addr_out  output  32  byte address of the instruction on instr_out.
REQ-013 SHALL have port ahb_ready_out  output  1  transfer-complete / accept indication (HREADY).
REQ-014 SHALL have port ahb_resp_out  output  1  error response (HRESP): 1 = ERROR.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, DATA, ERR1, ERR2.
REQ-016 SHALL accept a request in any cycle where state is IDLE or DATA and req_in=1; accepted address latched into addr_q.
REQ-017 SHALL, on acceptance, go to ERR1 if i_addr_in[1:0]!=0 or i_addr_in[31:2]>=MEM_DEPTH; else WAIT if WAIT_STATES>0; else DATA.
REQ-018 SHALL, in WAIT, drive ahb_ready_out=0, ahb_resp_out=0, and count; after exactly WAIT_STATES WAIT cycles go to DATA.
REQ-019 SHALL, in DATA, drive ahb_ready_out=1, ahb_resp_out=0, instr_out=mem[addr_q[31:2]], instr_addr_out=addr_q; memory read occurs in this cycle (combinational from addr_q).
REQ-020 SHALL give fetch latency: request accepted in cycle N -> data cycle N+1+WAIT_STATES.
REQ-021 SHALL, from DATA, go to IDLE when req_in=0, else apply REQ-017 to the new request (back-to-back fetches, no bubble).
REQ-022 SHALL, in ERR1, drive ahb_ready_out=0, ahb_resp_out=1; next state ERR2.
REQ-023 SHALL, in ERR2, drive ahb_ready_out=1, ahb_resp_out=1, instr_out=NOP_INSTR, instr_addr_out=addr_q; next state IDLE; req_in in ERR2 ignored.
REQ-024 SHALL, in IDLE, drive ahb_ready_out=1, ahb_resp_out=0, instr_out=NOP_INSTR, instr_addr_out=addr_q.
REQ-025 SHALL ignore req_in in WAIT and ERR1 (requester holds address while ready=0).
REQ-026 SHALL write mem[load_addr_in]=load_data_in at the clock edge whenever load_en_in=1, in any state.
REQ-027 SHALL, when a load targets addr_q before or at the edge preceding the data cycle, return the newly written word (write-before-read).
REQ-028 SHALL treat load_en_in=1 together with req_in=1 as independent: both take effect in the same cycle.
REQ-029 SHALL compute the wait counter as 4-bit, saturating never required (reloaded on each acceptance).

Reset
REQ-030 SHALL, when ms_riscv32_mp_rst_in=1 at a clock edge, set state=IDLE, wait counter=0, addr_q=0, giving ahb_ready_out=1, ahb_resp_out=0, instr_out=NOP_INSTR, instr_addr_out=0.
REQ-031 SHALL abort any in-flight fetch or error response on reset; no data cycle follows.
REQ-032 SHALL ignore req_in and load_en_in during reset cycles; memory contents are not cleared by reset.

Verification
REQ-033 Preload mem[4]=32'h00A0_0093, WAIT_STATES=1, req addr 0x10 in cycle N -> ready=0 in N+1, ready=1 with instr_out=32'h00A0_0093, instr_addr_out=0x10 in N+2.
REQ-034 WAIT_STATES=0, req_in held 1 with addrs 0x0,0x4,0x8 on consecutive accepts -> ready=1 every cycle, three data cycles back-to-back with mem[0],mem[1],mem[2].
REQ-035 Req addr 0x0000_0006 -> ERR1 (ready=0, resp=1) then ERR2 (ready=1, resp=1, instr_out=32'h0000_0013), then IDLE.
REQ-036 MEM_DEPTH=1024, req addr 0x0000_1000 -> two-cycle error response as REQ-035.
REQ-037 WAIT_STATES=3, req addr 0x20, load_en_in with load_addr_in=8, data 32'hDEAD_BEEF during second WAIT cycle -> data cycle returns 32'hDEAD_BEEF.
REQ-038 Reset asserted in WAIT -> next cycle ready=1, resp=0, instr_out=NOP_INSTR, instr_addr_out=0, no data cycle for the aborted fetch.

Source files
------------

// File: rtl/msrv32_imem_responder.sv
// Instruction-memory responder for the msrv32 fetch path: preloadable word memory
// answering fetches with an AHB-style ready/resp handshake, wait states and error response.
module msrv32_imem_responder #(
   parameter int          MEM_DEPTH   = 1024,
   parameter int          WAIT_STATES = 1,
   parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
   input  logic                         ms_riscv32_mp_clk_in,
   input  logic                         ms_riscv32_mp_rst_in,
   input  logic [31:0]                  i_addr_in,
   input  logic                         req_in,
   input  logic                         load_en_in,
   input  logic [$clog2(MEM_DEPTH)-1:0] load_addr_in,
   input  logic [31:0]                  load_data_in,
   output logic [31:0]                  instr_out,
   output logic [31:0]                  instr_addr_out,
   output logic                         ahb_ready_out,
   output logic                         ahb_resp_out,
   output logic [2:0]                   fsm_state
);

   // Handshake: a fetch is accepted in any cycle where ahb_ready_out=1 in IDLE or DATA
   // and req_in=1; while ahb_ready_out=0 the requester holds its address and req_in is ignored.

   localparam int          AW      = $clog2(MEM_DEPTH);
   localparam logic [29:0] DEPTH_W = 30'(MEM_DEPTH);
   localparam logic [3:0]  WS      = 4'(WAIT_STATES);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WAIT = 3'd1,
      S_DATA = 3'd2,
      S_ERR1 = 3'd3,
      S_ERR2 = 3'd4
   } state_t;

   state_t      state;
   state_t      accept_state;
   logic [3:0]  wait_cnt;
   logic [31:0] addr_q;
   logic [31:0] rd_word;
   logic        bad_addr;

   logic [31:0] mem [MEM_DEPTH];

   assign bad_addr     = (i_addr_in[1:0] != 2'b00) || (i_addr_in[31:2] >= DEPTH_W);
   assign accept_state = bad_addr ? S_ERR1 : ((WS != 4'd0) ? S_WAIT : S_DATA);

   always_ff @(posedge ms_riscv32_mp_clk_in) begin
      if (ms_riscv32_mp_rst_in) begin
         state    <= S_IDLE;
         wait_cnt <= 4'd0;
         addr_q   <= 32'd0;
      end else begin
         case (state)
            S_IDLE, S_DATA: begin
               if (req_in) begin
                  addr_q   <= i_addr_in;
                  wait_cnt <= WS;
                  state    <= accept_state;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_WAIT: begin
               // Counter is reloaded on every acceptance, so it never needs to saturate.
               wait_cnt <= wait_cnt - 4'd1;
               if (wait_cnt == 4'd1) begin
                  state <= S_DATA;
               end
            end
            S_ERR1:  state <= S_ERR2;
            S_ERR2:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Preload port writes in any state; the combinational read below sees the word
   // in the very next cycle, which gives write-before-read for the data cycle.
   always_ff @(posedge ms_riscv32_mp_clk_in) begin
      if (!ms_riscv32_mp_rst_in && load_en_in) begin
         mem[load_addr_in] <= load_data_in;
      end
   end

   assign rd_word = mem[addr_q[AW+1:2]];

   always_comb begin
      ahb_ready_out  = 1'b1;
      ahb_resp_out   = 1'b0;
      instr_out      = NOP_INSTR;
      instr_addr_out = addr_q;
      case (state)
         S_WAIT: ahb_ready_out = 1'b0;
         S_DATA: instr_out = rd_word;
         S_ERR1: begin
            ahb_ready_out = 1'b0;
            ahb_resp_out  = 1'b1;
         end
         S_ERR2: ahb_resp_out = 1'b1;
         default: ;
      endcase
   end

   assign fsm_state = state;

endmodule

// File: tb/tb_msrv32_imem_responder.sv
// Directed bench for msrv32_imem_responder: three instances (WAIT_STATES 1, 0, 3) share
// stimulus; a vector table drives the WAIT_STATES=1 instance, hand sequences cover the rest.
module tb_msrv32_imem_responder;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr;
   logic        req;
   logic        le;
   logic [9:0]  la;
   logic [31:0] ld;

   logic [31:0] r1_instr, r1_iaddr, r0_instr, r0_iaddr, r3_instr, r3_iaddr;
   logic        r1_ready, r1_resp, r0_ready, r0_resp, r3_ready, r3_resp;
   logic [2:0]  r1_state, r0_state, r3_state;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   msrv32_imem_responder #(.MEM_DEPTH(1024), .WAIT_STATES(1), .NOP_INSTR(NOP)) u_ws1 (
      .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst), .i_addr_in(addr), .req_in(req),
      .load_en_in(le), .load_addr_in(la), .load_data_in(ld), .instr_out(r1_instr),
      .instr_addr_out(r1_iaddr), .ahb_ready_out(r1_ready), .ahb_resp_out(r1_resp),
      .fsm_state(r1_state));

   msrv32_imem_responder #(.MEM_DEPTH(1024), .WAIT_STATES(0), .NOP_INSTR(NOP)) u_ws0 (
      .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst), .i_addr_in(addr), .req_in(req),
      .load_en_in(le), .load_addr_in(la), .load_data_in(ld), .instr_out(r0_instr),
      .instr_addr_out(r0_iaddr), .ahb_ready_out(r0_ready), .ahb_resp_out(r0_resp),
      .fsm_state(r0_state));

   msrv32_imem_responder #(.MEM_DEPTH(1024), .WAIT_STATES(3), .NOP_INSTR(NOP)) u_ws3 (
      .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst), .i_addr_in(addr), .req_in(req),
      .load_en_in(le), .load_addr_in(la), .load_data_in(ld), .instr_out(r3_instr),
      .instr_addr_out(r3_iaddr), .ahb_ready_out(r3_ready), .ahb_resp_out(r3_resp),
      .fsm_state(r3_state));

   typedef struct {
      logic        req;
      logic [31:0] addr;
      logic        le;
      logic [9:0]  la;
      logic [31:0] ld;
      logic        ready;
      logic        resp;
      logic        chk_data;
      logic [31:0] instr;
      logic [31:0] iaddr;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(input logic r, input logic [31:0] a, input logic l,
                               input logic [9:0] lai, input logic [31:0] ldi,
                               input logic rdy, input logic rsp, input logic cd,
                               input logic [31:0] ins, input logic [31:0] ia);
      vec_t v;
      v.req = r; v.addr = a; v.le = l; v.la = lai; v.ld = ldi;
      v.ready = rdy; v.resp = rsp; v.chk_data = cd; v.instr = ins; v.iaddr = ia;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [31:0] a, input logic l,
                        input logic [9:0] lai, input logic [31:0] ldi);
      req = r; addr = a; le = l; la = lai; ld = ldi;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 32'd0, 1'b0, 10'd0, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 32'd0, 1'b0, 10'd0, 32'd0);
      do_reset();

      // Reset state on every instance
      chk("rst ws1 ready", {31'd0, r1_ready}, 32'd1);
      chk("rst ws1 resp",  {31'd0, r1_resp},  32'd0);
      chk("rst ws1 instr", r1_instr, NOP);
      chk("rst ws1 iaddr", r1_iaddr, 32'd0);
      chk("rst ws0 ready", {31'd0, r0_ready}, 32'd1);
      chk("rst ws0 instr", r0_instr, NOP);
      chk("rst ws3 resp",  {31'd0, r3_resp},  32'd0);
      chk("rst ws3 iaddr", r3_iaddr, 32'd0);

      // WAIT_STATES=1 table: req, addr, le, la, ld | ready, resp, chk_data, instr, iaddr
      vt.push_back(mk(0, 32'h0,    1, 10'd4,    32'h00A0_0093, 1, 0, 1, NOP, 32'h0));
      vt.push_back(mk(0, 32'h0,    1, 10'd5,    32'h0050_0113, 1, 0, 1, NOP, 32'h0));
      vt.push_back(mk(0, 32'h0,    1, 10'd1023, 32'h1234_5678, 1, 0, 1, NOP, 32'h0));
      vt.push_back(mk(1, 32'h10,   0, 10'd0,    32'h0,         1, 0, 1, NOP, 32'h0));
      vt.push_back(mk(0, 32'h0,    0, 10'd0,    32'h0,         0, 0, 0, 32'h0, 32'h0));
      vt.push_back(mk(0, 32'h0,    0, 10'd0,    32'h0,         1, 0, 1, 32'h00A0_0093, 32'h10));
      vt.push_back(mk(1, 32'h6,    0, 10'd0,    32'h0,         1, 0, 1, NOP, 32'h10));
      vt.push_back(mk(1, 32'h14,   0, 10'd0,    32'h0,         0, 1, 0, 32'h0, 32'h0));
      vt.push_back(mk(1, 32'h14,   0, 10'd0,    32'h0,         1, 1, 1, NOP, 32'h6));
      vt.push_back(mk(1, 32'h1000, 0, 10'd0,    32'h0,         1, 0, 1, NOP, 32'h6));
      vt.push_back(mk(0, 32'h0,    0, 10'd0,    32'h0,         0, 1, 0, 32'h0, 32'h0));
      vt.push_back(mk(0, 32'h0,    0, 10'd0,    32'h0,         1, 1, 1, NOP, 32'h1000));
      vt.push_back(mk(1, 32'hFFC,  0, 10'd0,    32'h0,         1, 0, 1, NOP, 32'h1000));
      vt.push_back(mk(1, 32'h14,   0, 10'd0,    32'h0,         0, 0, 0, 32'h0, 32'h0));
      vt.push_back(mk(1, 32'h14,   0, 10'd0,    32'h0,         1, 0, 1, 32'h1234_5678, 32'hFFC));
      vt.push_back(mk(1, 32'h10,   0, 10'd0,    32'h0,         0, 0, 0, 32'h0, 32'h0));
      vt.push_back(mk(0, 32'h0,    0, 10'd0,    32'h0,         1, 0, 1, 32'h0050_0113, 32'h14));
      vt.push_back(mk(0, 32'h0,    0, 10'd0,    32'h0,         1, 0, 1, NOP, 32'h14));

      for (int i = 0; i < vt.size(); i++) begin
         @(negedge clk);
         drive(vt[i].req, vt[i].addr, vt[i].le, vt[i].la, vt[i].ld);
         chk($sformatf("v%0d ready", i), {31'd0, r1_ready}, {31'd0, vt[i].ready});
         chk($sformatf("v%0d resp", i),  {31'd0, r1_resp},  {31'd0, vt[i].resp});
         if (vt[i].chk_data) begin
            chk($sformatf("v%0d instr", i), r1_instr, vt[i].instr);
            chk($sformatf("v%0d iaddr", i), r1_iaddr, vt[i].iaddr);
         end
      end

      // WAIT_STATES=0: back-to-back fetches of words 0,1,2
      do_reset();
      drive(0, 32'h0, 1, 10'd0, 32'hA000_0001);
      @(negedge clk); drive(0, 32'h0, 1, 10'd1, 32'hA000_0002);
      @(negedge clk); drive(0, 32'h0, 1, 10'd2, 32'hA000_0003);
      @(negedge clk); drive(1, 32'h0, 0, 10'd0, 32'h0);
      chk("b2b idle ready", {31'd0, r0_ready}, 32'd1);
      @(negedge clk); drive(1, 32'h4, 0, 10'd0, 32'h0);
      chk("b2b d0 ready", {31'd0, r0_ready}, 32'd1);
      chk("b2b d0 resp",  {31'd0, r0_resp},  32'd0);
      chk("b2b d0 instr", r0_instr, 32'hA000_0001);
      chk("b2b d0 iaddr", r0_iaddr, 32'h0);
      @(negedge clk); drive(1, 32'h8, 0, 10'd0, 32'h0);
      chk("b2b d1 ready", {31'd0, r0_ready}, 32'd1);
      chk("b2b d1 instr", r0_instr, 32'hA000_0002);
      chk("b2b d1 iaddr", r0_iaddr, 32'h4);
      @(negedge clk); drive(0, 32'h0, 0, 10'd0, 32'h0);
      chk("b2b d2 ready", {31'd0, r0_ready}, 32'd1);
      chk("b2b d2 instr", r0_instr, 32'hA000_0003);
      chk("b2b d2 iaddr", r0_iaddr, 32'h8);
      @(negedge clk);
      chk("b2b end instr", r0_instr, NOP);

      // WAIT_STATES=3: load lands during the second wait cycle
      do_reset();
      drive(0, 32'h0, 1, 10'd8, 32'h1111_1111);
      @(negedge clk); drive(1, 32'h20, 0, 10'd0, 32'h0);
      chk("ws3 accept ready", {31'd0, r3_ready}, 32'd1);
      @(negedge clk); drive(0, 32'h0, 0, 10'd0, 32'h0);
      chk("ws3 w1 ready", {31'd0, r3_ready}, 32'd0);
      chk("ws3 w1 resp",  {31'd0, r3_resp},  32'd0);
      @(negedge clk); drive(0, 32'h0, 1, 10'd8, 32'hDEAD_BEEF);
      chk("ws3 w2 ready", {31'd0, r3_ready}, 32'd0);
      @(negedge clk); drive(0, 32'h0, 0, 10'd0, 32'h0);
      chk("ws3 w3 ready", {31'd0, r3_ready}, 32'd0);
      @(negedge clk);
      chk("ws3 data ready", {31'd0, r3_ready}, 32'd1);
      chk("ws3 data resp",  {31'd0, r3_resp},  32'd0);
      chk("ws3 data instr", r3_instr, 32'hDEAD_BEEF);
      chk("ws3 data iaddr", r3_iaddr, 32'h20);
      @(negedge clk);
      chk("ws3 idle instr", r3_instr, NOP);

      // Reset in WAIT aborts the fetch; request and load during reset are ignored
      drive(1, 32'h20, 0, 10'd0, 32'h0);
      @(negedge clk);
      chk("abort wait ready", {31'd0, r3_ready}, 32'd0);
      rst = 1'b1;
      drive(1, 32'h24, 1, 10'd8, 32'h0BAD_BAD0);
      @(negedge clk);
      rst = 1'b0;
      drive(0, 32'h0, 0, 10'd0, 32'h0);
      chk("abort ready", {31'd0, r3_ready}, 32'd1);
      chk("abort resp",  {31'd0, r3_resp},  32'd0);
      chk("abort instr", r3_instr, NOP);
      chk("abort iaddr", r3_iaddr, 32'h0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("abort quiet%0d ready", i), {31'd0, r3_ready}, 32'd1);
         chk($sformatf("abort quiet%0d instr", i), r3_instr, NOP);
      end
      drive(1, 32'h20, 0, 10'd0, 32'h0);
      @(negedge clk); drive(0, 32'h0, 0, 10'd0, 32'h0);
      @(negedge clk);
      @(negedge clk);
      chk("refetch w3 ready", {31'd0, r3_ready}, 32'd0);
      @(negedge clk);
      chk("refetch data ready", {31'd0, r3_ready}, 32'd1);
      chk("refetch data instr", r3_instr, 32'hDEAD_BEEF);

      $display("state probes at end: %0d %0d %0d", r1_state, r0_state, r3_state);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
